// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and helpers for the multi-cycle CPU control unit.
package cpu_ctrl_pkg;

    localparam int unsigned DEF_SEL_W = 3;
    localparam int unsigned DEF_NUM_T = 8;

    // Width of a one-hot bus decoded from a sel_w-bit index.
    function automatic int unsigned onehot_w(input int unsigned sel_w);
        return 32'(1) << sel_w;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Pure combinational binary-to-one-hot decoder; reused for step and register-select decode.
module onehot_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned IN_W = DEF_SEL_W
) (
    input  logic [IN_W-1:0]           sel_i,
    output logic [onehot_w(IN_W)-1:0] onehot_o
);

    localparam int unsigned OUT_W = onehot_w(IN_W);

    always_comb begin
        onehot_o = OUT_W'(1) << sel_i;
    end

endmodule

// File: rtl/timing_signal_gen.sv
// Micro-step sequence counter with clear/load/increment, wrap at NUM_T-1,
// one-hot step decode, last-step flag and illegal-load error pulse.
module timing_signal_gen
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned SEL_W = DEF_SEL_W,
    parameter int unsigned NUM_T = DEF_NUM_T
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       load_i,
    input  logic [SEL_W-1:0]           load_val_i,
    input  logic                       inc_i,
    output logic [SEL_W-1:0]           count_o,
    output logic [onehot_w(SEL_W)-1:0] t_o,
    output logic                       last_o,
    output logic                       err_o
);

    if (NUM_T < 1 || NUM_T > onehot_w(SEL_W)) begin : g_bad_num_t
        $fatal(1, "timing_signal_gen: NUM_T must be in 1..2**SEL_W");
    end

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_T - 1);

    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             load_legal;

    assign load_legal = (32'(load_val_i) < NUM_T);

    // Next-step selection: clear beats load beats increment beats hold.
    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            if (load_legal) begin
                cnt_d = load_val_i;
            end else begin
                err_d = 1'b1;
            end
        end else if (inc_i) begin
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign count_o = cnt_q;
    assign err_o   = err_q;
    assign last_o  = (cnt_q == LAST_IDX);

    onehot_decoder #(
        .IN_W(SEL_W)
    ) u_dec (
        .sel_i   (cnt_q),
        .onehot_o(t_o)
    );

endmodule

// File: tb/tb_timing_signal_gen.sv
// Self-checking bench: three instances (NUM_T = 8, 5, 1) driven by shared controls
// and compared each cycle against an arithmetic reference model.
module tb_timing_signal_gen;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       load;
    logic [2:0] load_val;
    logic       inc;

    logic [2:0] cnt8, cnt5, cnt1;
    logic [7:0] t8, t5, t1;
    logic       last8, last5, last1;
    logic       err8, err5, err1;

    int checks;
    int errors;

    int m_cnt [3];
    int m_err [3];
    int nt    [3];
    logic [12:0] obs [3];

    timing_signal_gen #(.SEL_W(3), .NUM_T(8)) u_n8 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
        .inc_i(inc), .count_o(cnt8), .t_o(t8), .last_o(last8), .err_o(err8));
    timing_signal_gen #(.SEL_W(3), .NUM_T(5)) u_n5 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
        .inc_i(inc), .count_o(cnt5), .t_o(t5), .last_o(last5), .err_o(err5));
    timing_signal_gen #(.SEL_W(3), .NUM_T(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
        .inc_i(inc), .count_o(cnt1), .t_o(t1), .last_o(last1), .err_o(err1));

    assign obs[0] = {cnt8, t8, last8, err8};
    assign obs[1] = {cnt5, t5, last5, err5};
    assign obs[2] = {cnt1, t1, last1, err1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {count, one-hot, last, err} from the model state.
    function automatic logic [12:0] expv(input int i);
        logic [2:0] c;
        logic [7:0] t;
        logic       l;
        c = 3'(m_cnt[i]);
        t = 8'(1 << m_cnt[i]);
        l = (m_cnt[i] + 1 == nt[i]);
        return {c, t, l, (m_err[i] != 0)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_err[i] = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < 3; i++) begin
            m_err[i] = 0;
            if (!rst_n) begin
                m_cnt[i] = 0;
            end else if (clr) begin
                m_cnt[i] = 0;
            end else if (load) begin
                if (int'(load_val) < nt[i]) m_cnt[i] = int'(load_val);
                else m_err[i] = 1;
            end else if (inc) begin
                m_cnt[i] = (m_cnt[i] + 1) % nt[i];
            end
        end
    endfunction

    task automatic cycle(input logic c, input logic l, input logic [2:0] v, input logic n);
        clr = c; load = l; load_val = v; inc = n;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr = 0; load = 0; load_val = 0; inc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
                errors++;
                $display("FAIL reset NUM_T=%0d got %h required %h", nt[i], obs[i], expv(i));
            end
        end
        checks++;
        if (t8 !== 8'h01) begin
            errors++;
            $display("FAIL reset_t8 got %h required 01", t8);
        end
    endtask

    task automatic test_increment();
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cycle(0, 0, 3'd0, 1);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== expv(i)) begin
                    errors++;
                    $display("FAIL inc step%0d NUM_T=%0d got %h required %h", k, nt[i], obs[i], expv(i));
                end
            end
        end
    endtask

    task automatic test_priority();
        cycle(1, 0, 3'd0, 0);
        repeat (3) cycle(0, 0, 3'd0, 1);
        checks++;
        if (cnt8 !== 3'd3) begin
            errors++;
            $display("FAIL prio_setup got %0d required 3", cnt8);
        end
        cycle(1, 1, 3'd6, 1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
                errors++;
                $display("FAIL prio_clr NUM_T=%0d got %h required %h", nt[i], obs[i], expv(i));
            end
        end
        cycle(0, 1, 3'd6, 1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
                errors++;
                $display("FAIL prio_load NUM_T=%0d got %h required %h", nt[i], obs[i], expv(i));
            end
        end
    endtask

    task automatic test_illegal_load();
        cycle(1, 0, 3'd0, 0);
        repeat (2) cycle(0, 0, 3'd0, 1);
        for (int k = 0; k < 4; k++) begin
            if (k < 2) cycle(0, 1, 3'd6, 1);
            else cycle(0, 0, 3'd0, 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== expv(i)) begin
                    errors++;
                    $display("FAIL illegal_load c%0d NUM_T=%0d got %h required %h", k, nt[i], obs[i], expv(i));
                end
            end
        end
        cycle(0, 1, 3'd1, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
                errors++;
                $display("FAIL load_one NUM_T=%0d got %h required %h", nt[i], obs[i], expv(i));
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 0, 3'd0, 0);
        repeat (6) cycle(0, 0, 3'd0, 1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
                errors++;
                $display("FAIL async_reset NUM_T=%0d got %h required %h", nt[i], obs[i], expv(i));
            end
        end
        #2;
        rst_n = 1'b1;
        cycle(0, 0, 3'd0, 1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
                errors++;
                $display("FAIL post_reset NUM_T=%0d got %h required %h", nt[i], obs[i], expv(i));
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(39, 0) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (obs[i] !== expv(i)) begin
                        errors++;
                        $display("FAIL rand_reset k%0d NUM_T=%0d got %h required %h", k, nt[i], obs[i], expv(i));
                    end
                end
                rst_n = 1'b1;
            end
            cycle(($urandom_range(15, 0) == 0), ($urandom_range(3, 0) == 0),
                  3'($urandom_range(7, 0)), ($urandom_range(1, 0) == 0));
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== expv(i)) begin
                    errors++;
                    $display("FAIL random k%0d NUM_T=%0d got %h required %h", k, nt[i], obs[i], expv(i));
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nt[0] = 8; nt[1] = 5; nt[2] = 1;
        test_reset();
        test_increment();
        test_priority();
        test_illegal_load();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
